// File: rtl/dmem_pkg.sv
// Shared constants and FSM encoding for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data port: request, write data, read data, stall and error.
interface data_mem_responder_if;

    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dout;
    logic [31:0] mem_din;
    logic        mem_stall;
    logic        mem_err;

    modport master (
        output mem_ren, mem_wen, mem_addr, mem_dout,
        input  mem_din, mem_stall, mem_err
    );

    modport slave (
        input  mem_ren, mem_wen, mem_addr, mem_dout,
        output mem_din, mem_stall, mem_err
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered, clearable read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] ram [0:(1<<ADDR_WIDTH)-1];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= ram[addr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: wait-state FSM in front of the data RAM.
// Optional address/request checking is enabled by defining DMEM_ERR_CHECK_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_responder_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  latch, do_access, stall;

    logic                  req;
    logic                  live_rd, live_wr, live_err;
    logic [ADDR_WIDTH-1:0] live_idx;

    logic                  op_rd, op_wr, op_err;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [WORD_W-1:0]     data_q;

    logic                  sel_rd, sel_wr, sel_err;
    logic [ADDR_WIDTH-1:0] sel_idx;
    logic [WORD_W-1:0]     sel_data;
    logic                  err_q;

    assign req      = bus.mem_ren | bus.mem_wen;
    assign live_idx = bus.mem_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ERR_CHECK_EN
    assign live_err = (bus.mem_ren & bus.mem_wen)
                    | (bus.mem_addr[1:0] != 2'b00)
                    | ((bus.mem_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign live_wr  = bus.mem_wen & ~live_err;
    assign live_rd  = bus.mem_ren & ~live_err;
`else
    // Addresses wrap modulo the RAM size; writes win over reads.
    logic unused_addr;
    assign unused_addr = ^{bus.mem_addr[1:0], bus.mem_addr[31:ADDR_WIDTH+2]};
    assign live_err = 1'b0;
    assign live_wr  = bus.mem_wen;
    assign live_rd  = bus.mem_ren & ~bus.mem_wen;
`endif

    // With zero wait states the access fires in IDLE, before anything is latched.
    assign sel_rd   = (state == IDLE) ? live_rd   : op_rd;
    assign sel_wr   = (state == IDLE) ? live_wr   : op_wr;
    assign sel_err  = (state == IDLE) ? live_err  : op_err;
    assign sel_idx  = (state == IDLE) ? live_idx  : idx_q;
    assign sel_data = (state == IDLE) ? bus.mem_dout : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        latch     = 1'b0;
        do_access = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    stall = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == '0) begin
                    do_access = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            // Inputs still show the completed instruction here, so req is ignored.
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_rd  <= 1'b0;
            op_wr  <= 1'b0;
            op_err <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (latch) begin
                op_rd  <= live_rd;
                op_wr  <= live_wr;
                op_err <= live_err;
            end
            err_q <= do_access & sel_err;
        end
    end

    always_ff @(posedge clk) begin
        if (latch) begin
            idx_q  <= live_idx;
            data_q <= bus.mem_dout;
        end
    end

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (do_access & sel_wr),
        .re    (do_access & sel_rd),
        .clr   (do_access & sel_err),
        .addr  (sel_idx),
        .wdata (sel_data),
        .rdata (bus.mem_din)
    );

    assign bus.mem_stall = stall & rst_n;
    assign bus.mem_err   = err_q;

endmodule
